hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. It generates the decode-stage branch forwarding selects consumed by the ID stage, and the execute-stage forwarding selects. It produces the fetch/decode stall and execute flush for load-use, branch-operand and multiply/divide-unit (MDU) hazards. It also sequences occupancy of the multi-cycle MDU and counts stall cycles for performance monitoring.

## Interface
Parameters:
- MULT_CYCLES, 4, MDU busy cycles for mult/multu (1..2^CNT_W)
- DIV_CYCLES, 32, MDU busy cycles for div/divu (1..2^CNT_W)
- CNT_W, 6, MDU countdown width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rsD, rtD  in  5 each  decode-stage source register numbers
- branchD  in  1  decode holds beq/bne (reads rs and rt)
- jrD  in  1  decode holds jr/jalr (reads rs only)
- mduUseD  in  1  decode holds mfhi/mflo/mthi/mtlo/mult/div
- rsE, rtE  in  5 each  execute-stage source registers
- writeRegAddrE, writeRegAddrM, writeRegAddrW  in  5 each  destination per stage
- Regfile_weE, Regfile_weM, Regfile_weW  in  1 each  register write enable per stage
- memToRegE, memToRegM  in  1 each  stage holds a load
- mduStartE  in  1  execute holds mult/multu/div/divu
- mduDivE  in  1  qualifies mduStartE: 1 = divide, 0 = multiply
- forwardAD, forwardBD  out  1 each  decode compare operand from aluOutM
- forwardAE, forwardBE  out  2 each  EX operand select: 00 = regfile, 01 = wbOut, 10 = aluOutM
- stallF, stallD  out  1 each  hold PC / hold IF-ID register
- flushE  out  1  bubble the ID-EX register
- mduBusy  out  1  MDU state not IDLE
- mduDone  out  1  one-cycle HI/LO write strobe
- mduErr  out  1  sticky: mduStartE seen while not IDLE
- stallCycles  out  32  saturating count of cycles with stallD=1

## Operation
Forwarding (combinational):
- forwardAE = 10 if Regfile_weM && writeRegAddrM!=0 && writeRegAddrM==rsE.
- Otherwise forwardAE = 01 if Regfile_weW && writeRegAddrW!=0 && writeRegAddrW==rsE.
- Otherwise forwardAE = 00. MEM has priority over WB.
- forwardBE follows the same rules using rtE.
- forwardAD = Regfile_weM && writeRegAddrM!=0 && writeRegAddrM==rsD. forwardBD is the same with rtD.

Stall sources (combinational):
- lwStall: memToRegE && writeRegAddrE!=0 && (writeRegAddrE==rsD || writeRegAddrE==rtD).
- brStall (branchD uses rs,rt; jrD uses rs only): either of the following matches a used source register:
  - Regfile_weE && writeRegAddrE!=0 && writeRegAddrE equals that register.
  - memToRegM && writeRegAddrM!=0 && writeRegAddrM equals that register.
- mduStall: mduUseD && (state!=IDLE || mduStartE).
- stallF = stallD = flushE = lwStall | brStall | mduStall.

MDU FSM (states IDLE, BUSY, DONE):
- IDLE:
  - If mduStartE: cnt <= (mduDivE ? DIV_CYCLES : MULT_CYCLES) - 1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt!=0: cnt <= cnt-1.
  - If cnt==0: go to DONE.
- DONE: mduDone=1; go to IDLE.
- mduStartE in BUSY or DONE is ignored (no reload) and sets mduErr; mduErr clears only on rst.
- mduBusy = (state!=IDLE).

stallCycles increments when stallD=1 and holds at 32'hFFFF_FFFF.

## Timing
- Forwarding and stall outputs are combinational from the current-cycle inputs, with zero latency.
- mduStartE sampled high in IDLE at cycle t:
  - BUSY during cycles t+1 .. t+N (N = selected cycle count).
  - DONE at t+N+1, with mduDone high in that cycle only.
  - IDLE at t+N+2.
  - mduStall covers t .. t+N+1 for a decode instruction with mduUseD.
- Back-to-back MDU ops: the second op is held in decode until the FSM returns to IDLE. It enters EX in cycle t+N+2 at the earliest.
- Reset (async, any state including mid-BUSY):
  - state=IDLE, cnt=0, mduErr=0, stallCycles=0.
  - mduBusy=0, mduDone=0, and all stall and forward outputs are driven by their inputs.
- Register 0 never causes forwarding or a stall.
- Multiple stall sources in the same cycle OR together; the response is still a single stall/flush.

## Test plan
- Write $3 in MEM, rsE=3, write $3 in WB -> forwardAE=10. Remove the MEM write -> forwardAE=01. Set writeRegAddrM=0 -> no MEM forward.
- lw $5 in EX (memToRegE=1, writeRegAddrE=5) with rtD=5 -> stallF=stallD=flushE=1 for one cycle. The next cycle (lw now in MEM) shows no stall and forwardBE resolves as expected.
- beq $2,$4 in decode with an ALU write of $4 in EX -> stall one cycle. The next cycle has forwardBD=1 and no stall. The same case with jrD and rtD=4 -> no stall.
- div starts (mduStartE=1, mduDivE=1) at cycle 10 and mfhi is in decode -> stall during cycles 10..43; mduDone=1 only in cycle 43; mduBusy=0 from cycle 44.
- mult starts, then async rst pulses mid-BUSY -> immediate IDLE, mduBusy=0, no mduDone pulse, stallCycles=0.
- Force mduStartE during BUSY -> cnt is not reloaded and mduErr=1 stays set until rst. Hold stallD high with stallCycles preloaded near max -> the counter saturates at FFFF_FFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: forwarding, stall/flush, MDU sequencing, stall counter
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        branchD,
    input  logic        jrD,
    input  logic        mduUseD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeRegAddrE,
    input  logic [4:0]  writeRegAddrM,
    input  logic [4:0]  writeRegAddrW,
    input  logic        Regfile_weE,
    input  logic        Regfile_weM,
    input  logic        Regfile_weW,
    input  logic        memToRegE,
    input  logic        memToRegM,
    input  logic        mduStartE,
    input  logic        mduDivE,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        mduBusy,
    output logic        mduDone,
    output logic        mduErr,
    output logic [31:0] stallCycles
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mdu_err_q, mdu_err_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;
    logic              lw_stall, br_stall, mdu_stall, stall;

    // A write to $0 is discarded by the regfile, so it never matches.
    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (hit(Regfile_weM, writeRegAddrM, rsE))      forwardAE = 2'b10;
        else if (hit(Regfile_weW, writeRegAddrW, rsE)) forwardAE = 2'b01;
        if (hit(Regfile_weM, writeRegAddrM, rtE))      forwardBE = 2'b10;
        else if (hit(Regfile_weW, writeRegAddrW, rtE)) forwardBE = 2'b01;
        forwardAD = hit(Regfile_weM, writeRegAddrM, rsD);
        forwardBD = hit(Regfile_weM, writeRegAddrM, rtD);
    end

    always_comb begin
        lw_stall  = hit(memToRegE, writeRegAddrE, rsD) || hit(memToRegE, writeRegAddrE, rtD);
        // Branch/jr compare in decode, so an EX ALU result or a MEM load is not ready yet.
        br_stall  = ((branchD || jrD) && (hit(Regfile_weE, writeRegAddrE, rsD) ||
                                          hit(memToRegM, writeRegAddrM, rsD))) ||
                    (branchD && (hit(Regfile_weE, writeRegAddrE, rtD) ||
                                 hit(memToRegM, writeRegAddrM, rtD)));
        mdu_stall = mduUseD && ((state_q != IDLE) || mduStartE);
        stall     = lw_stall || br_stall || mdu_stall;
        stallF    = stall;
        stallD    = stall;
        flushE    = stall;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mdu_err_d      = mdu_err_q;
        stall_cycles_d = stall_cycles_q;
        unique case (state_q)
            IDLE: if (mduStartE) begin
                cnt_d   = mduDivE ? DIV_LOAD : MULT_LOAD;
                state_d = BUSY;
            end
            BUSY: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                  else             state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (mduStartE && (state_q != IDLE)) mdu_err_d = 1'b1;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mdu_err_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mdu_err_q      <= mdu_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mduBusy     = (state_q != IDLE);
    assign mduDone     = (state_q == DONE);
    assign mduErr      = mdu_err_q;
    assign stallCycles = stall_cycles_q;
endmodule
